// File: rtl/dmem_access_unit_pkg.sv
// Shared definitions for dmem_access_unit: access-size encodings, FSM states and
// byte-count helpers used by both the controller and the lane aligner.
package dmem_access_unit_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC0 = 2'd1,
        ST_ACC1 = 2'd2,
        ST_WAIT = 2'd3
    } dmem_state_e;

    function automatic logic [2:0] size_to_nbytes(input logic [1:0] size);
        case (size)
            SZ_BYTE: size_to_nbytes = 3'd1;
            SZ_HALF: size_to_nbytes = 3'd2;
            SZ_WORD: size_to_nbytes = 3'd4;
            default: size_to_nbytes = 3'd4;
        endcase
    endfunction

    // True when the access spills past the end of its first word.
    function automatic logic is_cross(input logic [1:0] off, input logic [1:0] size);
        logic [3:0] last;
        last = {2'b00, off} + {1'b0, size_to_nbytes(size)};
        is_cross = (last > 4'd4);
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering for dmem_access_unit: store byte enables and data for
// both words of an access, plus load extraction with sign/zero extension.
module dmem_lane_align
    import dmem_access_unit_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_word0,
    input  logic [31:0] i_word1,
    output logic [3:0]  o_be0,
    output logic [3:0]  o_be1,
    output logic [31:0] o_wdata0,
    output logic [31:0] o_wdata1,
    output logic [31:0] o_rdata
);

    logic [2:0]  w_nbytes;
    logic [4:0]  w_shift;
    logic [7:0]  w_be_pair;
    logic [63:0] w_st_pair;
    logic [63:0] w_ld_pair;
    logic [31:0] w_ld_raw;

    assign w_nbytes  = size_to_nbytes(i_size);
    assign w_shift   = {i_off, 3'b000};

    // Byte mask and data are built across a two-word window; the upper half feeds word+1.
    assign w_be_pair = ((8'd1 << w_nbytes) - 8'd1) << i_off;
    assign w_st_pair = {32'd0, i_wdata} << w_shift;

    assign o_be0    = w_be_pair[3:0];
    assign o_be1    = w_be_pair[7:4];
    assign o_wdata0 = (i_size == SZ_BYTE) ? {4{i_wdata[7:0]}} : w_st_pair[31:0];
    assign o_wdata1 = w_st_pair[63:32];

    assign w_ld_pair = {i_word1, i_word0};
    assign w_ld_raw  = 32'(w_ld_pair >> w_shift);

    always_comb begin
        o_rdata = w_ld_raw;
        case (i_size)
            SZ_BYTE: o_rdata = {{24{i_signed & w_ld_raw[7]}}, w_ld_raw[7:0]};
            SZ_HALF: o_rdata = {{16{i_signed & w_ld_raw[15]}}, w_ld_raw[15:0]};
            default: o_rdata = w_ld_raw;
        endcase
    end

endmodule

// File: rtl/dmem_access_unit.sv
// Data-memory access unit: turns byte/half/word requests into word RAM cycles.
// Build option DMEM_MISALIGN_SPLIT_EN enables splitting word-crossing accesses.
module dmem_access_unit
    import dmem_access_unit_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int WA_W = ADDR_W - 2;

`ifdef DMEM_MISALIGN_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    dmem_state_e       r_state;
    dmem_state_e       w_next;
    logic              r_we;
    logic [1:0]        r_size;
    logic              r_signed;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_err;
    logic              r_rsp_valid;
    logic [31:0]       r_rsp_rdata;
    logic              r_rsp_err;

    logic              w_accept;
    logic              w_req_err;
    logic              w_cross;
    logic [WA_W-1:0]   w_word_addr;
    logic [31:0]       w_word0;
    logic [31:0]       w_word1;
    logic [3:0]        w_be0;
    logic [3:0]        w_be1;
    logic [31:0]       w_wdata0;
    logic [31:0]       w_wdata1;
    logic [31:0]       w_ld_data;

    assign req_ready   = (r_state == ST_IDLE);
    assign w_accept    = req_valid && req_ready;
    assign w_req_err   = (req_size == SZ_RSVD) || (!SPLIT_EN && is_cross(req_addr[1:0], req_size));
    assign w_cross     = is_cross(r_addr[1:0], r_size);
    assign w_word_addr = r_addr[ADDR_W-1:2];

`ifdef DMEM_MISALIGN_SPLIT_EN
    logic [31:0] r_lo;

    // Word 0 arrives during ACC1 and must be held until word 1 shows up in WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lo <= 32'd0;
        end else if (r_state == ST_ACC1) begin
            r_lo <= mem_rdata;
        end
    end

    assign w_word0 = w_cross ? r_lo : mem_rdata;
    assign w_word1 = w_cross ? mem_rdata : 32'd0;
`else
    assign w_word0 = mem_rdata;
    assign w_word1 = 32'd0;
`endif

    dmem_lane_align u_lane_align (
        .i_size   (r_size),
        .i_signed (r_signed),
        .i_off    (r_addr[1:0]),
        .i_wdata  (r_wdata),
        .i_word0  (w_word0),
        .i_word1  (w_word1),
        .o_be0    (w_be0),
        .o_be1    (w_be1),
        .o_wdata0 (w_wdata0),
        .o_wdata1 (w_wdata1),
        .o_rdata  (w_ld_data)
    );

    always_comb begin
        w_next    = r_state;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_be    = 4'd0;
        mem_addr  = '0;
        mem_wdata = 32'd0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next = w_req_err ? ST_WAIT : ST_ACC0;
                end
            end
            ST_ACC0: begin
                mem_en    = 1'b1;
                mem_we    = r_we;
                mem_be    = w_be0;
                mem_addr  = w_word_addr;
                mem_wdata = w_wdata0;
                w_next    = (SPLIT_EN && w_cross) ? ST_ACC1 : ST_WAIT;
            end
            ST_ACC1: begin
                mem_en    = 1'b1;
                mem_we    = r_we;
                mem_be    = w_be1;
                mem_addr  = w_word_addr + WA_W'(1);
                mem_wdata = w_wdata1;
                w_next    = ST_WAIT;
            end
            ST_WAIT: begin
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_we        <= 1'b0;
            r_size      <= SZ_BYTE;
            r_signed    <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= 32'd0;
            r_err       <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_rsp_valid <= 1'b0;
            if (w_accept) begin
                r_we     <= req_we;
                r_size   <= req_size;
                r_signed <= req_signed;
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
                r_err    <= w_req_err;
            end
            // The last read word is on mem_rdata during WAIT; the response appears in the next IDLE.
            if (r_state == ST_WAIT) begin
                r_rsp_valid <= 1'b1;
                r_rsp_err   <= r_err;
                r_rsp_rdata <= (r_err || r_we) ? 32'd0 : w_ld_data;
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

endmodule

// File: doc/dmem_access_unit.md
Name: dmem_access_unit

Overview:
- Memory-side responder for the control decoder's data-memory signals: MemRW, d_mem_access_size, dmem_is_signed.
- Sits between the datapath (ALU address, rs2 store data) and a word-wide synchronous data RAM.
- Converts byte/half/word requests into word accesses with byte enables, lane-shifts store data, and sign/zero-extends load data.
- Splits accesses that cross a word boundary into two memory cycles; uses a valid/ready request and a one-cycle response pulse.

Parameters:
- ADDR_W, 32, byte-address width; memory word address is ADDR_W-2 bits.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE
- req_we  in  1  1 = store, 0 = load (MemRW encoding)
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- req_signed  in  1  1 = sign-extend load (dmem_is_signed encoding)
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-aligned
- rsp_valid  out  1  one-cycle completion pulse, loads and stores
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  valid with rsp_valid
- mem_en  out  1  memory access this cycle
- mem_we  out  1  write strobe
- mem_be  out  4  byte enables, bit i = byte lane i (little-endian)
- mem_addr  out  ADDR_W-2  word address
- mem_wdata  out  32  lane-positioned write data
- mem_rdata  in  32  read data, valid the cycle after mem_en

Behaviour:
- Reset: asynchronous; all outputs 0 except req_ready=1; FSM goes to IDLE. Reset mid-access abandons the access; no rsp_valid is produced for it.
- Request handling: accepted on req_valid && req_ready. Address, size, signed, we and wdata are registered at acceptance.
- Derived fields:
  - off = addr[1:0]; nbytes = 1/2/4.
  - cross = (off + nbytes > 4).
- FSM states: IDLE, ACC0, ACC1, WAIT.
  - IDLE -> ACC0 on accept.
  - ACC0: mem_en=1 at word addr[ADDR_W-1:2]. Next state is ACC1 if cross, else WAIT.
  - ACC1: mem_en=1 at word+1; word0 mem_rdata captured into lo buffer. Next state WAIT.
  - WAIT: no memory access. Response registers are loaded from mem_rdata (and lo buffer) at the end of this cycle. Next state IDLE.
- Response timing: rsp_valid is high in the first IDLE cycle after WAIT, concurrently with req_ready=1, so back-to-back requests are supported.
  - Latency from accept cycle: 3 cycles non-crossing, 4 cycles crossing.
- Error path: size 11, or cross with the feature disabled, gives IDLE -> WAIT -> IDLE with no mem_en; rsp_err=1, rsp_rdata=0.
- Store byte enables:
  - word0: be = ((1<<nbytes)-1) << off, truncated to 4 bits.
  - word1: remaining high bits of that 8-bit mask, i.e. bits [7:4].
- Store data:
  - word0: mem_wdata = wdata << 8*off.
  - word1: mem_wdata = wdata >> 8*(4-off).
  - Byte stores additionally replicate the byte on all lanes (only the enabled lane matters).
- Load data:
  - Form {word1, word0} (word1 = 0 if not cross), shift right by 8*off, take low nbytes.
  - Sign-extend from bit 8*nbytes-1 if req_signed, else zero-extend; word loads ignore req_signed.
- Wrap: the word+1 address wraps modulo 2^(ADDR_W-2).

Optional Feature:
- Macro DMEM_MISALIGN_SPLIT_EN.
- Defined: crossing accesses are split as above.
- Undefined: ACC1 is unreachable, crossing requests take the error path (rsp_err=1, no mem_en), and the lo buffer is removed.
- Non-crossing unaligned accesses (e.g. half at off=1) succeed in both builds.

Decomposition:
- Shared package:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD;
  - FSM state enum;
  - function size_to_nbytes.
- One natural sub-module, dmem_lane_align: combinational store lane-shift/byte-enable generation plus load extract/extend. The parent holds only the FSM and registers.

Test Plan:
- Memory word 0x40 = 0x8899AABB. LB signed at 0x103 -> rsp_rdata 0xFFFFFF88, rsp_valid 3 cycles after accept, one mem_en at addr 0x40.
- LHU at 0x102 -> 0x00008899; LH at 0x102 -> 0xFFFF8899; LW at 0x100 -> 0x8899AABB.
- SB at 0x105, wdata 0x000000CC -> mem_addr 0x41, mem_be 0010, mem_we=1, lane1=0xCC; rsp_valid with rsp_err=0, rsp_rdata=0.
- Crossing (with DMEM_MISALIGN_SPLIT_EN), word 0x41 = 0x11223344:
  - LW at 0x102 -> mem_en at 0x40 then 0x41; rsp_rdata 0x33448899, 4-cycle latency.
  - SW at 0x103, data 0xDDCCBBAA -> be 1000 / wdata 0xAA000000, then be 0111 / wdata 0x00DDCCBB.
- Without the macro: the same LW 0x102 -> rsp_err=1, no mem_en, rsp_valid 2 cycles after accept. req_size=11 -> rsp_err=1 in both builds.
- Assert rst during ACC1 of a split load -> mem_en=0 immediately, req_ready=1, no rsp_valid. The next request completes normally.
